// File: rtl/me_pkg.sv
// Shared motion-estimation constants: block/search geometry defaults,
// derived widths and the pixel-feeder FSM state encoding.
package me_pkg;

  localparam int PEL_W     = 8;
  localparam int BLK_W_DEF = 4;
  localparam int BLK_H_DEF = 4;
  localparam int NPOS_DEF  = 4;
  localparam int SW_W_DEF  = BLK_W_DEF + NPOS_DEF - 1;

  // Width helper that never collapses to a zero-width vector for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TB_AW_DEF = clog2_min1(BLK_W_DEF * BLK_H_DEF);
  localparam int SW_AW_DEF = clog2_min1(SW_W_DEF * BLK_H_DEF);
  localparam int POS_W_DEF = clog2_min1(NPOS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH,
    ST_REPORT,
    ST_DONE
  } feed_state_t;

endpackage

// File: rtl/pel_addr_gen.sv
// Row/column/position counters for the SAD search walk and the derived
// template-block and search-window read addresses.
module pel_addr_gen
  import me_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int BLK_H = BLK_H_DEF,
  parameter int NPOS  = NPOS_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         clr,
  input  logic                                         step,
  input  logic                                         pos_clr,
  input  logic                                         pos_step,
  output logic [clog2_min1(BLK_W*BLK_H)-1:0]            tb_addr,
  output logic [clog2_min1((BLK_W+NPOS-1)*BLK_H)-1:0]   sw_addr,
  output logic [clog2_min1(NPOS)-1:0]                   pos,
  output logic                                         last_pix,
  output logic                                         last_pos
);

  localparam int SW_W  = BLK_W + NPOS - 1;
  localparam int R_W   = clog2_min1(BLK_H);
  localparam int C_W   = clog2_min1(BLK_W);
  localparam int TB_AW = clog2_min1(BLK_W * BLK_H);
  localparam int SW_AW = clog2_min1(SW_W * BLK_H);
  localparam int POS_W = clog2_min1(NPOS);

  logic [R_W-1:0] r;
  logic [C_W-1:0] c;

  assign last_pix = (r == R_W'(BLK_H - 1)) && (c == C_W'(BLK_W - 1));
  assign last_pos = (pos == POS_W'(NPOS - 1));

  // Raster walk over the block, column fastest; wraps to (0,0) after the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      c <= '0;
    end else if (clr) begin
      r <= '0;
      c <= '0;
    end else if (step) begin
      if (c == C_W'(BLK_W - 1)) begin
        c <= '0;
        r <= (r == R_W'(BLK_H - 1)) ? '0 : r + R_W'(1);
      end else begin
        c <= c + C_W'(1);
      end
    end
  end

  // Candidate position counter; saturates at the last position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (pos_clr) begin
      pos <= '0;
    end else if (pos_step && !last_pos) begin
      pos <= pos + POS_W'(1);
    end
  end

  // Address math is done at 32 bits so nothing wraps before the final sizing.
  assign tb_addr = TB_AW'(32'(r) * 32'(BLK_W) + 32'(c));
  assign sw_addr = SW_AW'(32'(r) * 32'(SW_W) + 32'(c) + 32'(pos));

endmodule

// File: rtl/pel_feeder.sv
// Sequencer feeding template/search-window pixel pairs into the SAD PE for
// every horizontal candidate position, flagging when each SAD is final.
module pel_feeder
  import me_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int BLK_H = BLK_H_DEF,
  parameter int NPOS  = NPOS_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         tb_rd,
  output logic [clog2_min1(BLK_W*BLK_H)-1:0]            tb_addr,
  input  logic [PEL_W-1:0]                             tb_data,
  output logic                                         sw_rd,
  output logic [clog2_min1((BLK_W+NPOS-1)*BLK_H)-1:0]   sw_addr,
  input  logic [PEL_W-1:0]                             sw_data,
  output logic                                         pe_clr,
  output logic                                         pe_en_sw,
  output logic                                         pe_en_tb,
  output logic [PEL_W-1:0]                             pe_pel_sw,
  output logic [PEL_W-1:0]                             pe_pel_tb,
  output logic                                         sad_valid,
  output logic [clog2_min1(NPOS)-1:0]                   pos_idx
);

  localparam int TB_AW = clog2_min1(BLK_W * BLK_H);
  localparam int SW_AW = clog2_min1((BLK_W + NPOS - 1) * BLK_H);
  localparam int POS_W = clog2_min1(NPOS);

  feed_state_t      state, state_nxt;
  logic             rd_p0, vld_p1, flush;
  logic             clr_rc, step, pos_clr, pos_step, last_pix, last_pos;
  logic [TB_AW-1:0] tb_addr_raw;
  logic [SW_AW-1:0] sw_addr_raw;
  logic [POS_W-1:0] pos;

  pel_addr_gen #(
    .BLK_W (BLK_W),
    .BLK_H (BLK_H),
    .NPOS  (NPOS)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_rc),
    .step     (step),
    .pos_clr  (pos_clr),
    .pos_step (pos_step),
    .tb_addr  (tb_addr_raw),
    .sw_addr  (sw_addr_raw),
    .pos      (pos),
    .last_pix (last_pix),
    .last_pos (last_pos)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nxt = state;
    rd_p0     = 1'b0;
    flush     = 1'b0;
    clr_rc    = 1'b0;
    step      = 1'b0;
    pos_clr   = 1'b0;
    pos_step  = 1'b0;
    pe_clr    = 1'b0;
    sad_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          pos_clr   = 1'b1;
          state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        pe_clr    = 1'b1;
        clr_rc    = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        rd_p0 = 1'b1;
        step  = 1'b1;
        if (last_pix) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        flush     = 1'b1;
        state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        sad_valid = 1'b1;
        pos_step  = 1'b1;
        state_nxt = last_pos ? ST_DONE : ST_CLR;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p0 -> p1: memory read issued, data returns next cycle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= rd_p0;
  end

  assign busy      = (state != ST_IDLE);
  assign tb_rd     = rd_p0;
  assign sw_rd     = rd_p0;
  assign tb_addr   = rd_p0 ? tb_addr_raw : '0;
  assign sw_addr   = rd_p0 ? sw_addr_raw : '0;
  // The FLUSH enable pushes the PE's last registered pair into its accumulator.
  assign pe_en_sw  = vld_p1 | flush;
  assign pe_en_tb  = vld_p1 | flush;
  assign pe_pel_sw = vld_p1 ? sw_data : '0;
  assign pe_pel_tb = vld_p1 ? tb_data : '0;
  assign pos_idx   = sad_valid ? pos : '0;

endmodule

// File: tb/tb_pel_feeder.sv
// Scoreboard bench for pel_feeder with synchronous-read memory models and a
// reference SAD processing element.
module tb_pel_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, tb_rd, sw_rd, pe_clr, pe_en_sw, pe_en_tb, sad_valid;
  logic [3:0] tb_addr;
  logic [4:0] sw_addr;
  logic [7:0] tb_data = 8'd0;
  logic [7:0] sw_data = 8'd0;
  logic [7:0] pe_pel_sw, pe_pel_tb;
  logic [1:0] pos_idx;

  pel_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .tb_rd     (tb_rd),
    .tb_addr   (tb_addr),
    .tb_data   (tb_data),
    .sw_rd     (sw_rd),
    .sw_addr   (sw_addr),
    .sw_data   (sw_data),
    .pe_clr    (pe_clr),
    .pe_en_sw  (pe_en_sw),
    .pe_en_tb  (pe_en_tb),
    .pe_pel_sw (pe_pel_sw),
    .pe_pel_tb (pe_pel_tb),
    .sad_valid (sad_valid),
    .pos_idx   (pos_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Synchronous-read memories.
  logic [7:0] tbm [16];
  logic [7:0] swm [28];
  always @(posedge clk) begin
    if (tb_rd) tb_data <= tbm[tb_addr];
    if (sw_rd) sw_data <= swm[sw_addr];
  end

  // Reference SAD PE: accumulates from its registered pixel pair.
  logic [7:0]  pr_sw = 8'd0, pr_tb = 8'd0;
  int unsigned sad = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad <= 0; pr_sw <= 8'd0; pr_tb <= 8'd0;
    end else if (pe_clr) begin
      sad <= 0; pr_sw <= 8'd0; pr_tb <= 8'd0;
    end else if (pe_en_sw) begin
      sad   <= sad + ((pr_sw > pr_tb) ? int'(pr_sw - pr_tb) : int'(pr_tb - pr_sw));
      pr_sw <= pe_pel_sw;
      pr_tb <= pe_pel_tb;
    end
  end

  typedef struct { int cyc; int pos; int sad; } sv_t;
  typedef struct { int cyc; int ta;  int sa;  } ad_t;
  sv_t sv_q[$];
  ad_t ad_q[$];
  int  clr_q[$];
  int  done_q[$];

  logic [34:0] allout;
  assign allout = {busy, done, tb_rd, tb_addr, sw_rd, sw_addr, pe_clr, pe_en_sw, pe_en_tb,
                   pe_pel_sw, pe_pel_tb, sad_valid, pos_idx};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: pops expectations as the DUT presents events.
  int en_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("en_equal", pe_en_sw, pe_en_tb);
      check("clr_en_overlap", longint'(pe_clr && pe_en_sw), 0);
      check("sv_overlap", longint'(sad_valid && (pe_clr || pe_en_sw)), 0);
      if (!pe_en_sw) check("pel_idle_zero", {pe_pel_sw, pe_pel_tb}, 0);
      if (pe_clr) begin
        en_cnt = 0;
        if (clr_q.size() == 0) unexpected("pe_clr");
        else check("clr_cycle", cyc, clr_q.pop_front());
      end
      if (pe_en_sw) en_cnt++;
      if (sad_valid) begin
        if (sv_q.size() == 0) unexpected("sad_valid");
        else begin
          sv_t e;
          e = sv_q.pop_front();
          check("sv_cycle", cyc, e.cyc);
          check("pos_idx", pos_idx, e.pos);
          check("sad", sad, e.sad);
          check("en_cycles", en_cnt, 17);
        end
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done");
        else check("done_cycle", cyc, done_q.pop_front());
      end
      if (ad_q.size() != 0 && ad_q[0].cyc == cyc) begin
        ad_t a;
        a = ad_q.pop_front();
        check("rd_strobe", {tb_rd, sw_rd}, 3);
        check("tb_addr", tb_addr, a.ta);
        check("sw_addr", sw_addr, a.sa);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input int kind);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++)
        tbm[r*4+c] = (kind == 0) ? 8'd10 : (kind == 1) ? 8'(c) : 8'((r*4+c)*37 + 11);
      for (int x = 0; x < 7; x++)
        swm[r*7+x] = (kind == 0) ? 8'd3 : (kind == 1) ? 8'(x) : 8'((r*7+x)*53 + 200);
    end
  endtask

  function automatic int model_sad(input int p);
    int s = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int a = int'(swm[r*7+c+p]);
        int b = int'(tbm[r*4+c]);
        s += (a > b) ? a - b : b - a;
      end
    return s;
  endfunction

  // Hand values for kinds 0 and 1, reference model for kind 2.
  task automatic push_run(input int t0, input int kind);
    for (int p = 0; p < 4; p++) begin
      sv_t e;
      e.cyc = t0 + 20 + 20*p;
      e.pos = p;
      e.sad = (kind == 0) ? 112 : (kind == 1) ? 16*p : model_sad(p);
      clr_q.push_back(t0 + 1 + 20*p);
      sv_q.push_back(e);
    end
    done_q.push_back(t0 + 81);
  endtask

  task automatic clear_q();
    sv_q.delete(); ad_q.delete(); clr_q.delete(); done_q.delete();
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((sv_q.size() + clr_q.size() + done_q.size() + ad_q.size()) != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_left", sv_q.size() + clr_q.size() + done_q.size() + ad_q.size(), 0);
    clear_q();
  endtask

  int t0;

  task automatic start_run(input int kind);
    start = 1'b1;
    t0 = cyc;
    push_run(t0, kind);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout global watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) tbm[i] = 8'd0;
    for (int i = 0; i < 28; i++) swm[i] = 8'd0;
    tick(); tick();
    check("reset_outputs", allout, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Constant blocks with address/timing spot checks.
    load_mem(0);
    begin
      ad_t a;
      t0 = cyc;
      a = '{t0 + 2, 0, 0};   ad_q.push_back(a);
      a = '{t0 + 5, 3, 3};   ad_q.push_back(a);
      a = '{t0 + 6, 4, 7};   ad_q.push_back(a);
      a = '{t0 + 22, 0, 1};  ad_q.push_back(a);
      a = '{t0 + 77, 15, 27}; ad_q.push_back(a);
    end
    start_run(0);
    wait_drain(200);
    check("busy_after_done", busy, 0);
    tick();

    // Column ramp pattern, with stray start pulses mid-search.
    load_mem(1);
    start_run(1);
    while (cyc != t0 + 10) tick();
    start = 1'b1; tick(); start = 1'b0;
    while (cyc != t0 + 50) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_drain(200);
    tick();

    // Reset mid-search, then a clean run.
    load_mem(2);
    start_run(2);
    while (cyc != t0 + 30) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", allout, 0);
    check("midreset_busy", busy, 0);
    clear_q();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", allout, 0);
    start_run(2);
    wait_drain(200);
    tick();

    // Start held high: second search accepted in the IDLE cycle after done.
    load_mem(0);
    start = 1'b1;
    t0 = cyc;
    push_run(t0, 0);
    push_run(t0 + 82, 0);
    while (cyc != t0 + 83) tick();
    start = 1'b0;
    wait_drain(200);
    check("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pel_feeder.md
# pel_feeder

Sequencer that produces the pixel streams consumed by the SAD processing element. On a `start` pulse it walks every candidate search position, reads template-block (TB) and search-window (SW) pixels from two synchronous-read memories, and drives the PE's `clr`/`en_sw`/`en_tb`/`pel_sw`/`pel_tb` inputs. It then flags when the PE's `sad` is final for each position. It sits between the frame-buffer memories and the SAD PE, upstream of the best-match comparator.

## Interface
- `BLK_W`, default 4: template block width in pixels.
- `BLK_H`, default 4: template block height in pixels.
- `NPOS`, default 4: number of horizontal candidate positions; SW row width `SW_W = BLK_W+NPOS-1`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a search; sampled only in IDLE.
- `busy`  out  1  high from the first cycle after `start` is accepted until return to IDLE.
- `done`  out  1  one-cycle pulse after the last position is reported.
- `tb_rd`  out  1  TB memory read strobe.
- `tb_addr`  out  `clog2(BLK_W*BLK_H)`  TB address = `r*BLK_W + c`.
- `tb_data`  in  8  TB read data, valid the cycle after `tb_rd`.
- `sw_rd`  out  1  SW memory read strobe.
- `sw_addr`  out  `clog2(SW_W*BLK_H)`  SW address = `r*SW_W + c + p`.
- `sw_data`  in  8  SW read data, valid the cycle after `sw_rd`.
- `pe_clr`  out  1  PE clear.
- `pe_en_sw`, `pe_en_tb`  out  1  PE load enables; always equal to each other.
- `pe_pel_sw`, `pe_pel_tb`  out  8  PE pixel inputs; 0 whenever the enables are low and in FLUSH.
- `sad_valid`  out  1  one-cycle pulse: the PE's `sad` holds the final SAD for `pos_idx`.
- `pos_idx`  out  `clog2(NPOS)`  candidate position being processed; valid with `sad_valid`.

## Operation
- FSM states: IDLE, CLR, RUN, DRAIN, FLUSH, REPORT, DONE.
- IDLE: `start`=1 → CLR with `p`=0. `start` is ignored in every other state.
- CLR (1 cycle): `pe_clr`=1; reset row/column counters `r`,`c` to 0.
- RUN (`N=BLK_W*BLK_H` cycles): `tb_rd`=`sw_rd`=1 with addresses for `(r,c)` in raster order, `c` fastest. After `(BLK_H-1,BLK_W-1)` → DRAIN.
- Data path: a read issued in cycle k is presented in cycle k+1. `pe_pel_*` equals the memory data and `pe_en_*`=1 via a registered read-valid. Enables are therefore high from RUN cycle 2 through DRAIN: N cycles.
- DRAIN (1 cycle): no read; last pixel pair is presented.
- FLUSH (1 cycle): `pe_en_*`=1, `pe_pel_*`=0. The PE accumulates from its registered pixels, so this cycle adds the last pair.
- REPORT (1 cycle): `sad_valid`=1, `pos_idx`=`p`. Next state is CLR with `p+1` if `p<NPOS-1`, else DONE.
- DONE (1 cycle): `done`=1 → IDLE.
- Counters are plain binary; `r`, `c`, `p` never exceed `BLK_H-1`, `BLK_W-1`, `NPOS-1`. Address arithmetic is unsigned and is not truncated below the declared widths.
- Reset, including mid-search: every output goes to 0, state goes to IDLE, counters to 0. There is no partial resume.

## Timing
- Cycle 1 is the first cycle after the edge that samples `start`. Per-position length is `L = N+4`, and position `p` starts at `b = 1+p*L`.
- CLR at `b`; reads at `b+1`..`b+N`; enables at `b+2`..`b+N+1`; FLUSH at `b+N+2`; `sad_valid` at `b+N+3`.
- `done` at cycle `1+NPOS*L`. `busy` is high cycles 1..`1+NPOS*L`, low the next cycle.
- For the defaults: `L`=20, `sad_valid` at 20/40/60/80, `done` at 81.
- A new `start` is accepted in the first IDLE cycle after `done`. Back-to-back searches therefore have a 1-cycle gap.
- `pe_clr` and `pe_en_*` are never high in the same cycle. `sad_valid` is never high with either.

## Structure
- Shared package `me_pkg`: `BLK_W`/`BLK_H`/`NPOS` defaults, derived `SW_W`, address-width constants, and the FSM state enum. The comparator and top level reuse these.
- One sub-module, `pel_addr_gen`: `r`/`c`/`p` counters and both address computations, with `step`, `clr`, and `last_pix`/`last_pos` flags. The FSM, read-valid pipeline register and output muxing stay in `pel_feeder`.

## Test plan
- TB all 10, SW all 3, `start` at cycle 0 → bench PE model gives `sad`=112 at each `sad_valid` (cycles 20/40/60/80, `pos_idx` 0..3); `done` at 81.
- TB `tb[r][c]=c`, SW `sw[r][x]=x` → `sad` = 0, 16, 32, 48 for `pos_idx` 0..3.
- Address/timing check → `pe_clr` at cycles 1/21/41/61. First reads at cycle 2: `tb_addr`=0, `sw_addr`=0. Read at cycle 22: `sw_addr`=1. Read at cycle 5 (`r=0,c=3,p=0`) → `sw_addr`=3; read at cycle 6 → `sw_addr`=7. Enables high exactly 16 cycles per position plus one FLUSH.
- `start` pulsed at cycles 10 and 50 during a search → ignored; timing identical to a single run.
- `rst_n` low at cycle 30 → all outputs 0 immediately, `busy`=0. New `start` after release → full clean run with correct SADs.
- `start` held high continuously → accepted at cycle 82, i.e. the IDLE cycle after `done`; second run's `sad_valid` at cycles 82+20=102, ...
